pipelined_barrel_shifter: RTL and testbench
===========================================

# pipelined_barrel_shifter

Parametrised, pipelined barrel shifter for the processor's ALU shift path. Supports logical left/right, arithmetic right and both rotates over a configurable data width. Optional pipeline registers sit between mux levels, and a valid/ready handshake with full backpressure makes it usable as a multi-cycle execute unit.

## Interface
- WIDTH, 32: data width; must be a power of two, at least 2.
- SHAMT_W, $clog2(WIDTH): shift-amount width, which equals the number of mux levels.
- LEVELS_PER_STAGE, 1: mux levels between pipeline registers; must be 1..SHAMT_W.
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  an operation is presented.
- in_ready  out  1  the shifter accepts the operation this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift distance, unsigned, 0..WIDTH-1.
- in_op  in  3  operation code (see Operation).
- out_valid  out  1  a result is presented.
- out_ready  in  1  the consumer takes the result this cycle.
- out_data  out  WIDTH  result.
- out_err  out  1  the result came from an illegal op code.

## Operation
- Op codes: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR. Codes 101–111 are illegal.
- Illegal op: the operand passes through unchanged and out_err=1 travels with that result.
- Level k (k=0..SHAMT_W-1) shifts by 2^k when shamt bit k is 1.
- Fill bits per level:
  - SLL and SRL: zero.
  - SRA: copy of the level input MSB, i.e. the original sign.
  - ROL and ROR: bits wrapped from the opposite end.
- Rotates are implemented as left/right rotate paths. ROL with shamt 0 returns the operand unchanged.
- Each pipeline register holds data, the remaining shamt bits, op, err and valid.
- Stage count NSTG = ceil(SHAMT_W / LEVELS_PER_STAGE). The last stage register drives the out_* ports directly.
- Handshake: a transfer happens on a cycle where valid and ready are both 1. in_data, in_shamt and in_op are sampled only on an input transfer.
- Stage s loads when !valid[s], or when stage s+1 loads (or out_ready for the last stage). This is a stall-propagating pipeline with no bubbles.
- in_ready equals the load condition of stage 0. It is combinational from out_ready through the stage valids.
- Once out_valid is asserted, out_data and out_err hold stable until a transfer completes.

## Timing
- Latency: exactly NSTG cycles from an input transfer to out_valid, provided no stall occurs. The WIDTH=32 default gives 5 cycles.
- Throughput: one operation per cycle while out_ready=1.
- Reset values (asynchronous assert, synchronous-safe deassert):
  - all stage valid bits 0, so out_valid=0;
  - out_data 0 and out_err 0;
  - in_ready=1 in the first cycle after reset.
- Reset mid-operation: all in-flight operations are discarded, with no partial outputs.
- Full pipeline with out_ready=0: in_ready=0, and no stage changes.
- A simultaneous output transfer and input transfer on a full pipeline is legal. Every stage shifts and no operation is lost or duplicated.
- Results leave in acceptance order. No reordering.
- Shamt 0 with any legal op: out_data = in_data.

## Structure
- shifter_pkg holds:
  - the op-code localparams (OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR);
  - an op-is-legal function;
  - the stage-count function ceil(SHAMT_W/LEVELS_PER_STAGE).
- Sub-module shift_level is one combinational mux level. Parameters: WIDTH and DIST (2^k). Inputs: data, enable bit, op. Output: data. It is instantiated SHAMT_W times in a generate loop.
- The top-level module owns the stage registers, the valid/ready chain and the err propagation.

## Test plan
- Shifts (WIDTH=32, default pipeline): each result appears on out_data after 5 cycles.
  - SLL 0x0000_0001 by 31 -> 0x8000_0000.
  - SRL 0x8000_0000 by 4 -> 0x0800_0000.
  - SRA 0x8000_0000 by 4 -> 0xF800_0000.
- Rotates:
  - ROR 0x0000_000F by 4 -> 0xF000_0000.
  - ROL 0x8000_0001 by 1 -> 0x0000_0003.
  - ROL 0x1234_5678 by 0 -> 0x1234_5678.
- Illegal op 110 on 0xDEAD_BEEF by 7 -> out_data 0xDEAD_BEEF with out_err=1. The next legal op returns out_err=0.
- Backpressure:
  - Stream 8 back-to-back ops with out_ready=0 from cycle 3. in_ready must drop once 5 are in flight.
  - Release out_ready. All 8 results must emerge in order, one per cycle, with out_data stable while stalled.
- Reset mid-operation: pulse reset_n low with 3 ops in flight. out_valid must go 0 immediately, none of those results may appear afterwards, and in_ready must be 1.
- Parameter sweep with a scoreboard:
  - WIDTH=8, LEVELS_PER_STAGE=3: 1 stage, latency 1.
  - WIDTH=64, LEVELS_PER_STAGE=2: 3 stages, latency 3.
  - 10k random ops with random out_ready, all matching a reference model.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op codes, op legality
// and the pipeline stage-count helper.
package shifter_pkg;

    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_SLL = 3'b000;
    localparam op_t OP_SRL = 3'b001;
    localparam op_t OP_SRA = 3'b010;
    localparam op_t OP_ROL = 3'b011;
    localparam op_t OP_ROR = 3'b100;

    function automatic logic op_is_legal(input op_t op);
        return op <= OP_ROR;
    endfunction

    // Pipeline registers needed when each stage holds levels_per_stage mux levels.
    function automatic int stage_count(input int shamt_w, input int levels_per_stage);
        return (shamt_w + levels_per_stage - 1) / levels_per_stage;
    endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational mux level of the barrel shifter: shifts or rotates by DIST
// when enabled. Illegal op codes pass the data through untouched.
module shift_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  op_t              op,
    output logic [WIDTH-1:0] shifted
);

    always_comb begin
        // NOTE: default assigned first so every path drives shifted; without it this infers a latch.
        shifted = data;
        if (en) begin
            case (op)
                OP_SLL:  shifted = data << DIST;
                OP_SRL:  shifted = data >> DIST;
                OP_SRA:  shifted = WIDTH'($signed(data) >>> DIST);
                OP_ROL:  shifted = {data[WIDTH-DIST-1:0], data[WIDTH-1:WIDTH-DIST]};
                OP_ROR:  shifted = {data[DIST-1:0], data[WIDTH-1:DIST]};
                default: shifted = data;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter for the ALU shift path: SHAMT_W mux levels grouped
// LEVELS_PER_STAGE per register stage, with a stall-propagating valid/ready chain.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int SHAMT_W          = $clog2(WIDTH),
    parameter int LEVELS_PER_STAGE = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  op_t                in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_err
);

    localparam int NSTG = stage_count(SHAMT_W, LEVELS_PER_STAGE);

    typedef struct packed {
        logic [WIDTH-1:0]   data;
        logic [SHAMT_W-1:0] shamt;
        op_t                op;
        logic               err;
    } stage_t;

    stage_t          stg_q [NSTG];
    stage_t          stg_d [NSTG];
    logic [NSTG-1:0] valid_q;
    logic [NSTG-1:0] load;
    logic            tail_full;

    // A stage may load unless it and every stage downstream is full and the
    // consumer is stalled; this is the !valid[s] || load[s+1] chain unrolled.
    always_comb begin
        tail_full = 1'b1;
        load      = '0;
        for (int s = NSTG - 1; s >= 0; s--) begin
            tail_full = tail_full & valid_q[s];
            load[s]   = out_ready | ~tail_full;
        end
    end

    assign in_ready = load[0];

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_level
        localparam int S = k / LEVELS_PER_STAGE;
        logic [WIDTH-1:0] lin;
        logic [WIDTH-1:0] lout;
        logic             lvl_en;
        op_t              lvl_op;

        if (S == 0) begin : g_src_port
            assign lvl_en = in_shamt[k];
            assign lvl_op = in_op;
        end else begin : g_src_reg
            assign lvl_en = stg_q[S-1].shamt[k];
            assign lvl_op = stg_q[S-1].op;
        end

        if (k % LEVELS_PER_STAGE != 0) begin : g_chain
            assign lin = g_level[k-1].lout;
        end else if (S == 0) begin : g_first
            assign lin = in_data;
        end else begin : g_boundary
            assign lin = stg_q[S-1].data;
        end

        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (2 ** k)
        ) u_level (
            .data    (lin),
            .en      (lvl_en),
            .op      (lvl_op),
            .shifted (lout)
        );
    end

    for (genvar s = 0; s < NSTG; s++) begin : g_stage
        localparam int END  = (s + 1) * LEVELS_PER_STAGE;
        localparam int LAST = ((END < SHAMT_W) ? END : SHAMT_W) - 1;

        if (s == 0) begin : g_head
            assign stg_d[s] = '{data:  g_level[LAST].lout,
                                shamt: in_shamt,
                                op:    in_op,
                                err:   !op_is_legal(in_op)};
        end else begin : g_body
            assign stg_d[s] = '{data:  g_level[LAST].lout,
                                shamt: stg_q[s-1].shamt,
                                op:    stg_q[s-1].op,
                                err:   stg_q[s-1].err};
        end
    end

    // Payload registers only capture real operations, so inputs are sampled
    // solely on a transfer and out_data holds while the pipeline drains.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int s = 0; s < NSTG; s++) begin
                stg_q[s] <= '0;
            end
        end else begin
            // NOTE: non-blocking so each stage captures its upstream neighbour's pre-edge value.
            if (load[0]) begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    stg_q[0] <= stg_d[0];
                end
            end
            for (int s = 1; s < NSTG; s++) begin
                if (load[s]) begin
                    valid_q[s] <= valid_q[s-1];
                    if (valid_q[s-1]) begin
                        stg_q[s] <= stg_d[s];
                    end
                end
            end
        end
    end

    assign out_valid = valid_q[NSTG-1];
    assign out_data  = stg_q[NSTG-1].data;
    assign out_err   = stg_q[NSTG-1].err;

    // The last stage's shamt/op have no further consumer.
    logic unused_tail;
    assign unused_tail = ^{stg_q[NSTG-1].shamt, stg_q[NSTG-1].op};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench: directed vector table, backpressure and reset sequences,
// and a random scoreboard sweep over three parameterisations.
module tb_pipelined_barrel_shifter;
    import shifter_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_data;
    logic [5:0]  in_shamt;
    op_t         in_op;
    int          sel;

    logic        rdy32, ov32, oe32;
    logic [31:0] od32;
    logic        rdy8, ov8, oe8;
    logic [7:0]  od8;
    logic        rdy64, ov64, oe64;
    logic [63:0] od64;

    logic        m_ready, m_valid, m_err;
    logic [63:0] m_data;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipelined_barrel_shifter #(.WIDTH(32), .LEVELS_PER_STAGE(1)) u_dut32 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid && (sel == 0)), .in_ready(rdy32),
        .in_data(in_data[31:0]), .in_shamt(in_shamt[4:0]), .in_op(in_op),
        .out_valid(ov32), .out_ready(out_ready), .out_data(od32), .out_err(oe32)
    );

    pipelined_barrel_shifter #(.WIDTH(8), .LEVELS_PER_STAGE(3)) u_dut8 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid && (sel == 1)), .in_ready(rdy8),
        .in_data(in_data[7:0]), .in_shamt(in_shamt[2:0]), .in_op(in_op),
        .out_valid(ov8), .out_ready(out_ready), .out_data(od8), .out_err(oe8)
    );

    pipelined_barrel_shifter #(.WIDTH(64), .LEVELS_PER_STAGE(2)) u_dut64 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid && (sel == 2)), .in_ready(rdy64),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(ov64), .out_ready(out_ready), .out_data(od64), .out_err(oe64)
    );

    always_comb begin
        case (sel)
            0:       begin m_ready = rdy32; m_valid = ov32; m_err = oe32; m_data = {32'h0, od32}; end
            1:       begin m_ready = rdy8;  m_valid = ov8;  m_err = oe8;  m_data = {56'h0, od8};  end
            default: begin m_ready = rdy64; m_valid = ov64; m_err = oe64; m_data = od64;          end
        endcase
    end

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bit-by-bit reference: result bit i is taken from its source bit position.
    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int sh, input op_t op, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (op)
                3'b000:  r[i] = (i >= sh) ? d[i-sh] : 1'b0;
                3'b001:  r[i] = (i + sh < w) ? d[i+sh] : 1'b0;
                3'b010:  r[i] = (i + sh < w) ? d[i+sh] : d[w-1];
                3'b011:  r[i] = d[(i - sh + w) % w];
                3'b100:  r[i] = d[(i + sh) % w];
                default: r[i] = d[i];
            endcase
        end
        return r;
    endfunction

    task automatic run_one(input string name, input int lat, input op_t op, input logic [63:0] d,
                           input int sh, input logic [63:0] exp, input logic exp_err);
        int c;
        @(negedge clock);
        in_valid  = 1'b1;
        in_op     = op;
        in_data   = d;
        in_shamt  = sh[5:0];
        out_ready = 1'b1;
        #1;
        check({name, "_in_ready"}, 65'(m_ready), 65'(1));
        @(negedge clock);
        in_valid = 1'b0;
        in_data  = ~d;
        in_op    = OP_SLL;
        in_shamt = 6'h3f;
        c = 1;
        while (!m_valid && c < 20) begin
            @(negedge clock);
            c++;
        end
        check({name, "_latency"}, 65'(c), 65'(lat));
        check({name, "_data"}, 65'(m_data), 65'(exp));
        check({name, "_err"}, 65'(m_err), 65'(exp_err));
    endtask

    typedef struct {
        string       name;
        op_t         op;
        logic [31:0] data;
        int          shamt;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bp_exp [8];
        logic [31:0] held;
        logic [64:0] q [$];
        logic [64:0] exp_e;
        int n_in, n_out, cyc, first_out, last_out, seen, issued, w;

        vecs[0]  = '{"sll31",   OP_SLL, 32'h0000_0001, 31, 32'h8000_0000, 1'b0};
        vecs[1]  = '{"srl4",    OP_SRL, 32'h8000_0000, 4,  32'h0800_0000, 1'b0};
        vecs[2]  = '{"sra4",    OP_SRA, 32'h8000_0000, 4,  32'hF800_0000, 1'b0};
        vecs[3]  = '{"ror4",    OP_ROR, 32'h0000_000F, 4,  32'hF000_0000, 1'b0};
        vecs[4]  = '{"rol1",    OP_ROL, 32'h8000_0001, 1,  32'h0000_0003, 1'b0};
        vecs[5]  = '{"rol0",    OP_ROL, 32'h1234_5678, 0,  32'h1234_5678, 1'b0};
        vecs[6]  = '{"ill110",  3'b110, 32'hDEAD_BEEF, 7,  32'hDEAD_BEEF, 1'b1};
        vecs[7]  = '{"post_ill",OP_SRL, 32'h0000_00F0, 4,  32'h0000_000F, 1'b0};
        vecs[8]  = '{"sra_pos", OP_SRA, 32'h7FFF_FFF0, 31, 32'h0000_0000, 1'b0};
        vecs[9]  = '{"sra0",    OP_SRA, 32'h8000_0001, 0,  32'h8000_0001, 1'b0};
        vecs[10] = '{"ror31",   OP_ROR, 32'h0000_0001, 31, 32'h0000_0002, 1'b0};
        vecs[11] = '{"rol31",   OP_ROL, 32'h0000_0001, 31, 32'h8000_0000, 1'b0};
        vecs[12] = '{"ill111",  3'b111, 32'h0123_4567, 3,  32'h0123_4567, 1'b1};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = OP_SLL;
        sel       = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check($sformatf("reset%0d_out_valid", s), 65'(m_valid), 65'(0));
            check($sformatf("reset%0d_out_data", s), 65'(m_data), 65'(0));
            check($sformatf("reset%0d_out_err", s), 65'(m_err), 65'(0));
            check($sformatf("reset%0d_in_ready", s), 65'(m_ready), 65'(1));
        end

        sel = 0;
        for (int i = 0; i < 13; i++) begin
            run_one(vecs[i].name, 5, vecs[i].op, {32'h0, vecs[i].data}, vecs[i].shamt,
                    {32'h0, vecs[i].exp}, vecs[i].err);
        end
        sel = 1;
        run_one("w8_ror3", 1, OP_ROR, 64'h81, 3, 64'h30, 1'b0);
        run_one("w8_sra7", 1, OP_SRA, 64'h80, 7, 64'hFF, 1'b0);
        sel = 2;
        run_one("w64_sll63", 3, OP_SLL, 64'h1, 63, 64'h8000_0000_0000_0000, 1'b0);
        run_one("w64_sra8", 3, OP_SRA, 64'h8000_0000_0000_0000, 8, 64'hFF80_0000_0000_0000, 1'b0);

        // Backpressure: consumer stalls from cycle 3 and releases at cycle 9.
        sel = 0;
        for (int i = 0; i < 8; i++) begin
            bp_exp[i] = ref_shift({32'h0, 32'hA5A5_0000 | 32'(i)}, 3 * i + 1, op_t'(i % 5), 32)[31:0];
        end
        n_in = 0; n_out = 0; cyc = 0; first_out = -1; last_out = -1; held = '0;
        @(negedge clock);
        while (n_out < 8 && cyc < 100) begin
            out_ready = (cyc < 3) || (cyc >= 9);
            in_valid  = (n_in < 8);
            in_data   = {32'h0, 32'hA5A5_0000 | 32'(n_in)};
            in_shamt  = 6'(3 * n_in + 1);
            in_op     = op_t'(n_in % 5);
            #1;
            if (cyc == 5) begin
                check("bp_in_ready_low", 65'(m_ready), 65'(0));
                check("bp_in_flight", 65'(n_in), 65'(5));
                held = m_data[31:0];
            end
            if (cyc == 8) begin
                check("bp_stall_valid", 65'(m_valid), 65'(1));
                check("bp_stall_stable", 65'(m_data), 65'(held));
            end
            if (m_valid && out_ready) begin
                check($sformatf("bp_result%0d", n_out), 65'(m_data), 65'(bp_exp[n_out]));
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                n_out++;
            end
            if (in_valid && m_ready) n_in++;
            cyc++;
            @(negedge clock);
        end
        in_valid = 1'b0;
        check("bp_count", 65'(n_out), 65'(8));
        check("bp_contiguous", 65'(last_out - first_out), 65'(7));

        // Reset with three operations in flight, the oldest waiting at the output.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = {32'h0, 32'h5555_0000 | 32'(i)};
            in_shamt = 6'(i);
            in_op    = OP_SLL;
            @(negedge clock);
        end
        in_valid = 1'b0;
        cyc = 0;
        while (!m_valid && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        check("rst_pre_valid", 65'(m_valid), 65'(1));
        reset_n = 1'b0;
        #1;
        check("rst_out_valid", 65'(m_valid), 65'(0));
        check("rst_out_data", 65'(m_data), 65'(0));
        check("rst_in_ready", 65'(m_ready), 65'(1));
        @(negedge clock);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready_after", 65'(m_ready), 65'(1));
        seen = 0;
        repeat (10) begin
            @(negedge clock);
            #1;
            if (m_valid) seen++;
        end
        check("rst_no_stale", 65'(seen), 65'(0));

        // Random scoreboard sweep over all three configurations.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            w = (s == 0) ? 32 : (s == 1) ? 8 : 64;
            issued = 0;
            cyc = 0;
            q.delete();
            while ((issued < 3400 || q.size() > 0) && cyc < 40000) begin
                @(negedge clock);
                in_valid  = (issued < 3400) && ($urandom_range(0, 9) < 7);
                in_data   = {$urandom, $urandom};
                in_shamt  = 6'($urandom_range(0, w - 1));
                in_op     = op_t'($urandom_range(0, 7));
                out_ready = ($urandom_range(0, 9) < 6);
                #1;
                if (m_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check($sformatf("rnd%0d_spurious", s), 65'(1), 65'(0));
                    end else begin
                        exp_e = q.pop_front();
                        check($sformatf("rnd%0d_result", s), {m_err, m_data}, exp_e);
                    end
                end
                if (in_valid && m_ready) begin
                    q.push_back({in_op > 3'b100, ref_shift(in_data, int'(in_shamt), in_op, w)});
                    issued++;
                end
                cyc++;
            end
            in_valid = 1'b0;
            check($sformatf("rnd%0d_drained", s), 65'(q.size() + (3400 - issued)), 65'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
